apb_timer8: RTL and testbench
=============================

Name: apb_timer8

Overview:
- 8-bit programmable up/down timer with an APB slave register interface.
- Registers: data/reload (TDR), control (TCR), status (TSR), counter readback (TCNT).
- The counter is clocked by an internal PCLK prescaler tap (÷2/4/8/16), selected by TCR.
- Sticky overflow and underflow flags drive the TMR_OVF and TMR_URF interrupt outputs.

Parameters:
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 8, register, counter and APB data width.

Ports:
- PCLK  in  1  single system clock; all logic on rising edge.
- PRESET_n  in  1  reset; synchronous and active-high (asserted = 1, sampled on PCLK rising edge).
- PSEL  in  1  APB select.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  APB access phase.
- PADDR  in  ADDR_WIDTH  register address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer ready.
- PSLVERR  out  1  transfer error.
- TMR_OVF  out  1  overflow flag (equals TSR[0]).
- TMR_URF  out  1  underflow flag (equals TSR[1]).

Behaviour:
- Address map:
  - TDR 0x00: R/W.
  - TCR 0x01: R/W.
  - TSR 0x02: R/W0C.
  - TCNT 0x03: read-only.
  - All other addresses are invalid.
- Reset: TDR, TCR, TSR, TCNT and the prescaler all clear to 0; PRDATA=0, PREADY=0, PSLVERR=0, TMR_OVF=0, TMR_URF=0. Reset has priority over everything, including mid-transfer.
- APB handshake (zero wait states):
  - PREADY = PSEL & PENABLE (combinational).
  - A write takes effect on every PCLK edge with PSEL & PENABLE & PWRITE & valid write address. A held access phase rewrites the same value, which is harmless.
- PRDATA: when PSEL & !PWRITE, combinationally returns the addressed register. It returns 0 for invalid addresses and 0 when not reading.
- PSLVERR = PSEL & PENABLE & invalid. "Invalid" means:
  - any unmapped address; or
  - a write to TCNT.
  - Invalid writes modify nothing.
- TCR bit fields:
  - [7] Load.
  - [5] Up/Dw (0 = up, 1 = down).
  - [4] En.
  - [1:0] Cks.
  - Bits 6, 3 and 2 are reserved: written value ignored, read 0.
- TSR bit fields:
  - [0] OVF, [1] UDF; other bits read 0.
  - Writing 0 to a flag bit clears it; writing 1 has no effect.
  - Writing any value to TSR while both flags are clear reads back 0x00.
  - If a hardware set and a software clear hit the same cycle, the set wins.
- Prescaler:
  - Free-running 4-bit counter incremented every PCLK.
  - Selected clock = prescaler bit Cks: 00 gives ÷2, 01 ÷4, 10 ÷8, 11 ÷16.
- Edge detection:
  - The selected clock is sampled into a previous-value register each PCLK.
  - A count event occurs when current=1 and previous=0.
  - Changing Cks may produce one extra event; this is acceptable.
- Counter update priority, per PCLK:
  1. If TCR[7]=1: TCNT ← TDR (level-sensitive, every cycle while set); counting is suppressed.
  2. Else if En=1 and a count event occurs: TCNT ← TCNT+1 (up) or TCNT−1 (down), modulo 256.
  3. Otherwise TCNT holds.
- Flags:
  - Counting up from 0xFF to 0x00 sets TSR[0].
  - Counting down from 0x00 to 0xFF sets TSR[1].
  - Flags stay set until cleared by software.
  - A load never sets a flag.
- Writing TDR does not change TCNT until the next load.
- TCNT is readable at any time, including while counting.

Test Plan:
- Reset defaults: after reset, read 0x00..0x03 → all 0x00; PSLVERR=0.
- TSR write/readback: write 20 random values to 0x02 → every read returns 0x00. Also read and write 0x02 with the access phase held 3 extra cycles → read data 0x00, no error.
- Load path:
  - write TDR=0xA5, read TDR → 0xA5;
  - write TCR=0x80, then TCR=0x00 → TCNT reads 0xA5;
  - write TCR with Cks 00/01/10/11 → TCR[1:0] reads back the same value.
- Overflow:
  - TDR=0xFF, load, TCR=0x10, two count events → TCNT=0x01, TMR_OVF=1, TSR=0x01;
  - write TSR=0x00 → TMR_OVF=0.
- Underflow: TDR=0x00, load, TCR=0x30, two count events → TCNT=0xFE, TMR_URF=1, TSR[1]=1.
- Error response:
  - write to 0x03 or any address ≥ 0x04 → PSLVERR=1 during the access phase, no register changes;
  - read of 0x7F → PRDATA=0x00, PSLVERR=1;
  - valid addresses → PSLVERR=0.

Source files
------------

// File: rtl/apb_timer8.sv
// rtl/apb_timer8.sv - 8-bit up/down timer with prescaled count clock and APB register access
// Registers: TDR 0x00, TCR 0x01, TSR 0x02 (write-0-to-clear flags), TCNT 0x03 (read-only).
module apb_timer8 #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET_n,
   input  logic                  PSEL,
   input  logic                  PWRITE,
   input  logic                  PENABLE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  TMR_OVF,
   output logic                  TMR_URF
);

   localparam logic [ADDR_WIDTH-1:0] A_TDR  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_TCR  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_TSR  = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_TCNT = ADDR_WIDTH'(3);
   // Implemented TCR bits: Load[7], Up/Dw[5], En[4], Cks[1:0]
   localparam logic [DATA_WIDTH-1:0] TCR_MASK = DATA_WIDTH'(8'hB3);

   logic [DATA_WIDTH-1:0] tdr;
   logic [DATA_WIDTH-1:0] tcr;
   logic [DATA_WIDTH-1:0] tcnt;
   logic [1:0]            tsr;
   logic [1:0]            tsr_next;
   logic [3:0]            presc;
   logic                  clk_prev;

   logic hit_tdr, hit_tcr, hit_tsr, hit_tcnt;
   logic access, invalid, wr_en;
   logic tcr_load, tcr_down, tcr_en;
   logic [1:0] tcr_cks;
   logic sel_clk, cnt_evt, counting, ovf_set, udf_set;

   assign tcr_load = tcr[7];
   assign tcr_down = tcr[5];
   assign tcr_en   = tcr[4];
   assign tcr_cks  = tcr[1:0];

   assign hit_tdr  = (PADDR == A_TDR);
   assign hit_tcr  = (PADDR == A_TCR);
   assign hit_tsr  = (PADDR == A_TSR);
   assign hit_tcnt = (PADDR == A_TCNT);

   // TCNT is readable but not writable, so the valid set differs by direction
   assign invalid = PWRITE ? !(hit_tdr | hit_tcr | hit_tsr)
                           : !(hit_tdr | hit_tcr | hit_tsr | hit_tcnt);
   assign access  = PSEL & PENABLE;
   assign wr_en   = access & PWRITE & !invalid;

   assign PREADY  = access;
   assign PSLVERR = access & invalid;
   assign TMR_OVF = tsr[0];
   assign TMR_URF = tsr[1];

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (1'b1)
            hit_tdr:  PRDATA = tdr;
            hit_tcr:  PRDATA = tcr;
            hit_tsr:  PRDATA = DATA_WIDTH'(tsr);
            hit_tcnt: PRDATA = tcnt;
            default:  PRDATA = '0;
         endcase
      end
   end

   assign sel_clk  = presc[tcr_cks];
   assign cnt_evt  = sel_clk & ~clk_prev;
   assign counting = !tcr_load & tcr_en & cnt_evt;
   assign ovf_set  = counting & !tcr_down & (tcnt == '1);
   assign udf_set  = counting &  tcr_down & (tcnt == '0);

   // Software clear is applied first so a same-cycle hardware set wins
   always_comb begin
      tsr_next = tsr;
      if (wr_en && hit_tsr)
         tsr_next = tsr & PWDATA[1:0];
      tsr_next = tsr_next | {udf_set, ovf_set};
   end

   always_ff @(posedge PCLK) begin
      if (PRESET_n) begin
         tdr      <= '0;
         tcr      <= '0;
         tsr      <= '0;
         tcnt     <= '0;
         presc    <= '0;
         clk_prev <= 1'b0;
      end else begin
         presc    <= presc + 4'd1;
         clk_prev <= sel_clk;
         tsr      <= tsr_next;
         if (wr_en && hit_tdr)
            tdr <= PWDATA;
         if (wr_en && hit_tcr)
            tcr <= PWDATA & TCR_MASK;
         if (tcr_load)
            tcnt <= tdr;
         else if (counting)
            tcnt <= tcr_down ? tcnt - 1'b1 : tcnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_timer8.sv
// tb/tb_apb_timer8.sv - scenario tasks with an expected-read-data queue for apb_timer8
module tb_apb_timer8;

   logic       PCLK = 1'b0;
   logic       PRESET_n = 1'b1;
   logic       PSEL = 1'b0;
   logic       PWRITE = 1'b0;
   logic       PENABLE = 1'b0;
   logic [7:0] PADDR = 8'h00;
   logic [7:0] PWDATA = 8'h00;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;
   logic       TMR_OVF;
   logic       TMR_URF;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   apb_timer8 #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .PCLK(PCLK), .PRESET_n(PRESET_n), .PSEL(PSEL), .PWRITE(PWRITE),
      .PENABLE(PENABLE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .TMR_OVF(TMR_OVF), .TMR_URF(TMR_URF)
   );

   always #5 PCLK = ~PCLK;

   // Called just after a rising edge; returns 1 time unit after the final access edge
   task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input int hold,
                            output logic err, output logic rdy);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      #1;
      repeat (hold) begin @(posedge PCLK); #1; end
      err = PSLVERR; rdy = PREADY;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, input int hold,
                           output logic [7:0] d, output logic err, output logic rdy);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      #1;
      repeat (hold) begin @(posedge PCLK); #1; end
      d = PRDATA; err = PSLVERR; rdy = PREADY;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] rd, exp;
      logic err, rdy;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PRESET_n = 1'b1;
      repeat (3) @(posedge PCLK);
      #1;
      checks++;
      if ({PREADY, PSLVERR, TMR_OVF, TMR_URF} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got rdy/err/ovf/urf=%b expected 0000",
                  {PREADY, PSLVERR, TMR_OVF, TMR_URF});
      end
      checks++;
      if (PRDATA !== 8'h00) begin
         errors++;
         $display("FAIL reset_prdata: got %h expected 00", PRDATA);
      end
      PRESET_n = 1'b0;
      for (int a = 0; a < 4; a++) begin
         exp_q.push_back(8'h00);
         apb_read(8'(a), 0, rd, err, rdy);
         exp = exp_q.pop_front();
         checks++;
         if (rd !== exp) begin
            errors++;
            $display("FAIL reset_read_%0d: got %h expected %h", a, rd, exp);
         end
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pslverr_%0d: got %b expected 0", a, err);
         end
      end
   endtask

   task automatic test_tsr_rw();
      logic [7:0] rd, exp;
      logic err, rdy;
      for (int i = 0; i < 20; i++) begin
         apb_write(8'h02, 8'($urandom_range(0, 255)), 0, err, rdy);
         exp_q.push_back(8'h00);
         apb_read(8'h02, 0, rd, err, rdy);
         exp = exp_q.pop_front();
         checks++;
         if (rd !== exp) begin
            errors++;
            $display("FAIL tsr_rand_%0d: got %h expected %h", i, rd, exp);
         end
      end
      apb_write(8'h02, 8'hFF, 3, err, rdy);
      checks++;
      if (err !== 1'b0 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL tsr_hold_write: got err=%b rdy=%b expected err=0 rdy=1", err, rdy);
      end
      exp_q.push_back(8'h00);
      apb_read(8'h02, 3, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp || err !== 1'b0) begin
         errors++;
         $display("FAIL tsr_hold_read: got %h err=%b expected %h err=0", rd, err, exp);
      end
   endtask

   task automatic test_load();
      logic [7:0] rd, exp;
      logic err, rdy;
      apb_write(8'h00, 8'hA5, 0, err, rdy);
      exp_q.push_back(8'hA5);
      apb_read(8'h00, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL tdr_readback: got %h expected %h", rd, exp);
      end
      apb_write(8'h01, 8'h80, 0, err, rdy);
      apb_write(8'h01, 8'h00, 0, err, rdy);
      exp_q.push_back(8'hA5);
      apb_read(8'h03, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL tcnt_after_load: got %h expected %h", rd, exp);
      end
      apb_write(8'h00, 8'h3C, 0, err, rdy);
      exp_q.push_back(8'hA5);
      apb_read(8'h03, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL tcnt_tdr_no_load: got %h expected %h", rd, exp);
      end
      // Reserved bits 6,3,2 are set on every write and must read back 0
      for (int c = 0; c < 4; c++) begin
         apb_write(8'h01, 8'h4C | 8'(c), 0, err, rdy);
         exp_q.push_back(8'(c));
         apb_read(8'h01, 0, rd, err, rdy);
         exp = exp_q.pop_front();
         checks++;
         if (rd !== exp) begin
            errors++;
            $display("FAIL tcr_cks_%0d: got %h expected %h", c, rd, exp);
         end
      end
      apb_write(8'h01, 8'h00, 0, err, rdy);
   endtask

   // Enable is live for exactly four PCLK edges at /2, giving two count events
   task automatic run_two_events(input logic [7:0] tdr_val, input logic [7:0] tcr_val);
      logic err, rdy;
      apb_write(8'h00, tdr_val, 0, err, rdy);
      apb_write(8'h01, 8'h80, 0, err, rdy);
      apb_write(8'h01, tcr_val, 0, err, rdy);
      repeat (2) @(posedge PCLK);
      #1;
      apb_write(8'h01, 8'h00, 0, err, rdy);
   endtask

   task automatic test_overflow();
      logic [7:0] rd, exp;
      logic err, rdy;
      run_two_events(8'hFF, 8'h10);
      exp_q.push_back(8'h01);
      apb_read(8'h03, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL ovf_tcnt: got %h expected %h", rd, exp);
      end
      checks++;
      if (TMR_OVF !== 1'b1 || TMR_URF !== 1'b0) begin
         errors++;
         $display("FAIL ovf_irq: got ovf=%b urf=%b expected ovf=1 urf=0", TMR_OVF, TMR_URF);
      end
      apb_write(8'h02, 8'h03, 0, err, rdy);
      exp_q.push_back(8'h01);
      apb_read(8'h02, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL ovf_tsr_w1_noeffect: got %h expected %h", rd, exp);
      end
      apb_write(8'h02, 8'h00, 0, err, rdy);
      checks++;
      if (TMR_OVF !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got ovf=%b expected 0", TMR_OVF);
      end
   endtask

   task automatic test_underflow();
      logic [7:0] rd, exp;
      logic err, rdy;
      run_two_events(8'h00, 8'h30);
      exp_q.push_back(8'hFE);
      apb_read(8'h03, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL udf_tcnt: got %h expected %h", rd, exp);
      end
      checks++;
      if (TMR_URF !== 1'b1 || TMR_OVF !== 1'b0) begin
         errors++;
         $display("FAIL udf_irq: got urf=%b ovf=%b expected urf=1 ovf=0", TMR_URF, TMR_OVF);
      end
      exp_q.push_back(8'h02);
      apb_read(8'h02, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL udf_tsr: got %h expected %h", rd, exp);
      end
   endtask

   task automatic test_error();
      logic [7:0] rd, exp;
      logic [7:0] bad_addr[4];
      logic [7:0] reg_exp[4];
      logic err, rdy;
      bad_addr = '{8'h03, 8'h04, 8'h80, 8'hFF};
      reg_exp  = '{8'h00, 8'h00, 8'h02, 8'hFE};
      for (int i = 0; i < 4; i++) begin
         apb_write(bad_addr[i], 8'hB7, 0, err, rdy);
         checks++;
         if (err !== 1'b1 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL err_write_%h: got err=%b rdy=%b expected err=1 rdy=1",
                     bad_addr[i], err, rdy);
         end
      end
      exp_q.push_back(8'h00);
      apb_read(8'h7F, 0, rd, err, rdy);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp || err !== 1'b1) begin
         errors++;
         $display("FAIL err_read_7f: got %h err=%b expected %h err=1", rd, err, exp);
      end
      for (int a = 0; a < 4; a++) begin
         exp_q.push_back(reg_exp[a]);
         apb_read(8'(a), 0, rd, err, rdy);
         exp = exp_q.pop_front();
         checks++;
         if (rd !== exp || err !== 1'b0) begin
            errors++;
            $display("FAIL err_unchanged_%0d: got %h err=%b expected %h err=0", a, rd, err, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tsr_rw();
      test_load();
      test_overflow();
      test_underflow();
      test_error();
      test_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
